// File: rtl/aqed_frame_tracker_if.sv
// Per-channel buffer handshake bundle between a producer/consumer and aqed_frame_tracker.
// The master drives depth and strobes; the tracker (slave) returns gates, counters and frame pulses.
interface aqed_frame_tracker_if #(
    parameter int N_CH  = 1,
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0]      depth;
    logic [N_CH-1:0]       wen;
    logic [N_CH-1:0]       ren;
    logic [N_CH-1:0]       wen_allow;
    logic [N_CH-1:0]       ren_allow;
    logic [N_CH*CNT_W-1:0] count_wen;
    logic [N_CH*CNT_W-1:0] count_ren;
    logic [N_CH-1:0]       frame_done;

    modport master (
        output depth, wen, ren,
        input  wen_allow, ren_allow, count_wen, count_ren, frame_done
    );

    modport slave (
        input  depth, wen, ren,
        output wen_allow, ren_allow, count_wen, count_ren, frame_done
    );
endinterface

// File: rtl/aqed_frame_tracker.sv
// A-QED frame tracker: per-channel write/read frame counters with gating, frame completion
// pulses, and sticky protocol / lag / config / response-bound / QED-compare error flags.
module aqed_frame_tracker #(
    parameter int N_CH       = 1,
    parameter int CNT_W      = 16,
    parameter int BOUND_MULT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    aqed_frame_tracker_if.slave bus,
    input  logic                orig_issued,
    input  logic                orig_done,
    input  logic                qed_done,
    input  logic                qed_check,
    output logic                proto_err,
    output logic                lag_err,
    output logic                cfg_err,
    output logic                bound_fail,
    output logic                qed_fail
);
    localparam int ACC_W = CNT_W + 3;
    localparam int SUM_W = ACC_W + 1;
    localparam int BND_W = CNT_W + 32;
    localparam int PC_W  = $clog2(N_CH + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, acc} + SUM_W'(inc);
        if (sum[ACC_W]) begin
            return '1;
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    logic [CNT_W-1:0]      cnt_w_r [N_CH];
    logic [CNT_W-1:0]      cnt_r_r [N_CH];
    logic [CNT_W-1:0]      nxt_w_s [N_CH];
    logic [CNT_W-1:0]      nxt_r_s [N_CH];
    logic [CNT_W-1:0]      depth_q_r;
    logic [N_CH-1:0]       frame_done_r;
    logic [N_CH-1:0]       wen_allow_s;
    logic [N_CH-1:0]       ren_allow_s;
    logic [N_CH-1:0]       wr_cnt_s;
    logic [N_CH-1:0]       rd_cnt_s;
    logic [N_CH-1:0]       complete_s;
    logic [N_CH*CNT_W-1:0] count_wen_s;
    logic [N_CH*CNT_W-1:0] count_ren_s;
    logic                  proto_s;
    logic                  lag_s;
    logic                  busy_s;
    logic                  cfg_s;
    logic                  bound_hit_s;
    logic [BND_W-1:0]      bound_s;
    logic                  issued_q_r;
    logic                  done_q_r;
    logic [ACC_W-1:0]      rd_after_r;
    logic [ACC_W-1:0]      wr_after_r;
    logic                  proto_err_r;
    logic                  lag_err_r;
    logic                  cfg_err_r;
    logic                  bound_fail_r;
    logic                  qed_fail_r;

    // Per-channel gating, counted strobes, next counts, completion and error detection.
    always_comb begin
        wen_allow_s = '0;
        ren_allow_s = '0;
        wr_cnt_s    = '0;
        rd_cnt_s    = '0;
        complete_s  = '0;
        count_wen_s = '0;
        count_ren_s = '0;
        proto_s     = 1'b0;
        lag_s       = 1'b0;
        busy_s      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            wen_allow_s[i] = (depth_q_r != '0) && (cnt_w_r[i] < depth_q_r);
            ren_allow_s[i] = (depth_q_r != '0) && (cnt_r_r[i] < depth_q_r);
            wr_cnt_s[i]    = clk_en & bus.wen[i] & wen_allow_s[i];
            rd_cnt_s[i]    = clk_en & bus.ren[i] & ren_allow_s[i];
            nxt_w_s[i]     = cnt_w_r[i] + CNT_W'(wr_cnt_s[i]);
            nxt_r_s[i]     = cnt_r_r[i] + CNT_W'(rd_cnt_s[i]);
            // Requiring a counted strobe keeps depth_q==0 from completing empty frames.
            if ((wr_cnt_s[i] | rd_cnt_s[i]) && (nxt_w_s[i] == depth_q_r) && (nxt_r_s[i] == depth_q_r)) begin
                complete_s[i] = 1'b1;
            end else begin
                complete_s[i] = 1'b0;
            end
            proto_s = proto_s | (clk_en & ((bus.wen[i] & ~wen_allow_s[i]) | (bus.ren[i] & ~ren_allow_s[i])));
            lag_s   = lag_s | ({1'b0, cnt_w_r[i]} > ({1'b0, cnt_r_r[i]} + {1'b0, depth_q_r}));
            busy_s  = busy_s | (cnt_w_r[i] != '0) | (cnt_r_r[i] != '0);
            count_wen_s[i*CNT_W +: CNT_W] = cnt_w_r[i];
            count_ren_s[i*CNT_W +: CNT_W] = cnt_r_r[i];
        end
    end

    // Config change and response-bound conditions from registered state.
    always_comb begin
        cfg_s       = clk_en & busy_s & (bus.depth != depth_q_r);
        bound_s     = BND_W'(depth_q_r) * BND_W'(BOUND_MULT);
        bound_hit_s = (BND_W'(rd_after_r) >= bound_s) && (wr_after_r >= ACC_W'(depth_q_r))
                      && !done_q_r && (depth_q_r != '0);
    end

    // Frame counters and the one-cycle frame completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_w_r[i] <= '0;
                cnt_r_r[i] <= '0;
            end
            frame_done_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_w_r[i] <= complete_s[i] ? '0 : nxt_w_s[i];
                cnt_r_r[i] <= complete_s[i] ? '0 : nxt_r_s[i];
            end
            frame_done_r <= complete_s;
        end
    end

    // Depth is only (re)captured while every channel is between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q_r <= '0;
        end else if (clk_en && !busy_s) begin
            depth_q_r <= bus.depth;
        end else begin
            depth_q_r <= depth_q_r;
        end
    end

    // Original-transaction tracking and post-issue traffic accumulators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q_r <= 1'b0;
            done_q_r   <= 1'b0;
            rd_after_r <= '0;
            wr_after_r <= '0;
        end else begin
            issued_q_r <= issued_q_r | (clk_en & orig_issued);
            done_q_r   <= done_q_r | orig_done;
            if (issued_q_r) begin
                rd_after_r <= sat_add(rd_after_r, popcount(rd_cnt_s));
                wr_after_r <= sat_add(wr_after_r, popcount(wr_cnt_s));
            end else begin
                rd_after_r <= rd_after_r;
                wr_after_r <= wr_after_r;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err_r  <= 1'b0;
            lag_err_r    <= 1'b0;
            cfg_err_r    <= 1'b0;
            bound_fail_r <= 1'b0;
            qed_fail_r   <= 1'b0;
        end else begin
            proto_err_r  <= proto_err_r | proto_s;
            lag_err_r    <= lag_err_r | (clk_en & lag_s);
            cfg_err_r    <= cfg_err_r | cfg_s;
            bound_fail_r <= bound_fail_r | (clk_en & bound_hit_s);
            qed_fail_r   <= qed_fail_r | (clk_en & qed_done & ~qed_check);
        end
    end

    assign bus.wen_allow  = wen_allow_s;
    assign bus.ren_allow  = ren_allow_s;
    assign bus.count_wen  = count_wen_s;
    assign bus.count_ren  = count_ren_s;
    assign bus.frame_done = frame_done_r;
    assign proto_err      = proto_err_r;
    assign lag_err        = lag_err_r;
    assign cfg_err        = cfg_err_r;
    assign bound_fail     = bound_fail_r;
    assign qed_fail       = qed_fail_r;
endmodule
